gamestate_ctrl: RTL and testbench

Parametrised game-flow controller for the frogger top level: sequences menu, play, pause, death animation, level-up banner, game-over and win. Tracks level and remaining lives and raises one-shot sound requests. Sits between the input/collision logic and the renderer and sound blocks. Supersedes the fixed 16-level, single-life controller.

---
 rtl/gamestate_pkg.sv | 27 ++
 rtl/gamestate_ctrl_tick_timer.sv | 29 ++
 rtl/gamestate_ctrl.sv | 154 +++++++++++++++
 tb/tb_gamestate_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gamestate_pkg.sv
// Shared types for the frogger game-flow controller: state and sound codes.
package gamestate_pkg;

    typedef enum logic [2:0] {
        ST_MENU      = 3'd0,
        ST_PLAYING   = 3'd1,
        ST_PAUSED    = 3'd2,
        ST_DYING     = 3'd3,
        ST_LEVEL_UP  = 3'd4,
        ST_GAME_OVER = 3'd5,
        ST_WIN       = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        SND_NONE     = 3'd0,
        SND_START    = 3'd1,
        SND_DEATH    = 3'd2,
        SND_LEVELUP  = 3'd3,
        SND_GAMEOVER = 3'd4,
        SND_WIN      = 3'd5
    } sound_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gamestate_ctrl_tick_timer.sv
// Frame-tick hold timer: loads a count, decrements on enabled ticks and
// flags the tick that brings it to zero.
module tick_timer #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    // done marks the tick being consumed as the last one of the hold
    assign done = en && (count == WIDTH'(1));

endmodule

// File: rtl/gamestate_ctrl.sv
// Game-flow sequencer: menu/play/pause/death/level-up/game-over/win with
// level and lives tracking, respawn strobe and one-shot sound requests.
//
// state     | meaning
// MENU      | waiting for start
// PLAYING   | frog live; collision/goal/pause act here only
// PAUSED    | frozen until the next pause pulse
// DYING     | death animation, DEATH_TICKS frame ticks
// LEVEL_UP  | level banner, LEVELUP_TICKS frame ticks
// GAME_OVER | no lives left; start returns to menu
// WIN       | last level cleared; start returns to menu
module gamestate_ctrl
    import gamestate_pkg::*;
#(
    parameter  int NUM_LEVELS    = 16,
    parameter  int NUM_LIVES     = 3,
    parameter  int DEATH_TICKS   = 60,
    parameter  int LEVELUP_TICKS = 30,
    localparam int LEVEL_W       = $clog2(NUM_LEVELS),
    localparam int LIVES_W       = $clog2(NUM_LIVES + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               tick,
    input  logic               start,
    input  logic               pause,
    input  logic               collision,
    input  logic               reached_end,
    output state_t             state,
    output logic [LEVEL_W-1:0] level,
    output logic [LIVES_W-1:0] lives,
    output logic               respawn,
    output sound_t             sound_select,
    output logic               sound_valid
);

    localparam int TIMER_W = $clog2(max_int(DEATH_TICKS, LEVELUP_TICKS) + 1);
    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [LIVES_W-1:0] FULL_LIVES = LIVES_W'(NUM_LIVES);

    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_en;
    logic               timer_done;

    // The timer is loaded on the same edge that enters DYING/LEVEL_UP, so a
    // tick coincident with entry is never counted.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = '0;
        if (state == ST_PLAYING) begin
            if (collision) begin
                timer_load  = 1'b1;
                timer_value = TIMER_W'(DEATH_TICKS);
            end else if (reached_end && level != LAST_LEVEL) begin
                timer_load  = 1'b1;
                timer_value = TIMER_W'(LEVELUP_TICKS);
            end
        end
    end

    assign timer_en = tick && (state == ST_DYING || state == ST_LEVEL_UP);

    tick_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (timer_load),
        .load_value (timer_value),
        .en         (timer_en),
        .done       (timer_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_MENU;
            level        <= '0;
            lives        <= FULL_LIVES;
            respawn      <= 1'b0;
            sound_select <= SND_NONE;
            sound_valid  <= 1'b0;
        end else begin
            respawn     <= 1'b0;
            sound_valid <= 1'b0;
            case (state)
                ST_MENU: begin
                    if (start) begin
                        state        <= ST_PLAYING;
                        level        <= '0;
                        lives        <= FULL_LIVES;
                        respawn      <= 1'b1;
                        sound_select <= SND_START;
                        sound_valid  <= 1'b1;
                    end
                end
                ST_PLAYING: begin
                    if (collision) begin
                        state        <= ST_DYING;
                        lives        <= lives - LIVES_W'(1);
                        sound_select <= SND_DEATH;
                        sound_valid  <= 1'b1;
                    end else if (reached_end) begin
                        sound_valid <= 1'b1;
                        if (level != LAST_LEVEL) begin
                            state        <= ST_LEVEL_UP;
                            level        <= level + LEVEL_W'(1);
                            sound_select <= SND_LEVELUP;
                        end else begin
                            state        <= ST_WIN;
                            sound_select <= SND_WIN;
                        end
                    end else if (pause) begin
                        state <= ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (pause) begin
                        state <= ST_PLAYING;
                    end
                end
                ST_DYING: begin
                    if (timer_done) begin
                        if (lives != '0) begin
                            state   <= ST_PLAYING;
                            respawn <= 1'b1;
                        end else begin
                            state        <= ST_GAME_OVER;
                            sound_select <= SND_GAMEOVER;
                            sound_valid  <= 1'b1;
                        end
                    end
                end
                ST_LEVEL_UP: begin
                    if (timer_done) begin
                        state   <= ST_PLAYING;
                        respawn <= 1'b1;
                    end
                end
                ST_GAME_OVER, ST_WIN: begin
                    if (start) begin
                        state <= ST_MENU;
                        level <= '0;
                        lives <= FULL_LIVES;
                    end
                end
                default: begin
                    state <= ST_MENU;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gamestate_ctrl.sv
// Bench for gamestate_ctrl: directed scenarios with literal checks, then random
// stimulus, all compared every cycle against a rule-level reference model.
module tb_gamestate_ctrl;
    import gamestate_pkg::*;

    localparam int NL = 16;
    localparam int NV = 3;
    localparam int DT = 60;
    localparam int LT = 30;
    localparam int LEVEL_W = $clog2(NL);
    localparam int LIVES_W = $clog2(NV + 1);

    logic               clk = 1'b0;
    logic               reset_n;
    logic               tick, start, pause, collision, reached_end;
    state_t             dut_state;
    logic [LEVEL_W-1:0] dut_level;
    logic [LIVES_W-1:0] dut_lives;
    logic               dut_respawn;
    sound_t             dut_sound;
    logic               dut_sv;

    int n_vec = 0;
    int n_err = 0;

    gamestate_ctrl #(
        .NUM_LEVELS (NL), .NUM_LIVES (NV), .DEATH_TICKS (DT), .LEVELUP_TICKS (LT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .tick         (tick),
        .start        (start),
        .pause        (pause),
        .collision    (collision),
        .reached_end  (reached_end),
        .state        (dut_state),
        .level        (dut_level),
        .lives        (dut_lives),
        .respawn      (dut_respawn),
        .sound_select (dut_sound),
        .sound_valid  (dut_sv)
    );

    always #5 clk = ~clk;

    // Reference model: game rules applied once per clock to the sampled inputs.
    state_t m_state = ST_MENU;
    int     m_level = 0;
    int     m_lives = NV;
    int     m_left  = 0;
    bit     m_respawn = 1'b0;
    bit     m_sv = 1'b0;
    sound_t m_sound = SND_NONE;

    task automatic m_play_sound(input sound_t s);
        m_sound = s;
        m_sv    = 1'b1;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_state = ST_MENU; m_level = 0; m_lives = NV; m_left = 0;
            m_respawn = 1'b0; m_sv = 1'b0; m_sound = SND_NONE;
        end else begin
            m_respawn = 1'b0;
            m_sv      = 1'b0;
            case (m_state)
                ST_MENU:
                    if (start) begin
                        m_state = ST_PLAYING; m_level = 0; m_lives = NV;
                        m_respawn = 1'b1; m_play_sound(SND_START);
                    end
                ST_PLAYING:
                    if (collision) begin
                        m_state = ST_DYING; m_lives = m_lives - 1; m_left = DT;
                        m_play_sound(SND_DEATH);
                    end else if (reached_end) begin
                        if (m_level < NL - 1) begin
                            m_state = ST_LEVEL_UP; m_level = m_level + 1; m_left = LT;
                            m_play_sound(SND_LEVELUP);
                        end else begin
                            m_state = ST_WIN; m_play_sound(SND_WIN);
                        end
                    end else if (pause) begin
                        m_state = ST_PAUSED;
                    end
                ST_PAUSED:
                    if (pause) m_state = ST_PLAYING;
                ST_DYING, ST_LEVEL_UP:
                    if (tick) begin
                        m_left = m_left - 1;
                        if (m_left == 0) begin
                            if (m_state == ST_DYING && m_lives == 0) begin
                                m_state = ST_GAME_OVER; m_play_sound(SND_GAMEOVER);
                            end else begin
                                m_state = ST_PLAYING; m_respawn = 1'b1;
                            end
                        end
                    end
                default:
                    if (start) begin
                        m_state = ST_MENU; m_level = 0; m_lives = NV;
                    end
            endcase
        end
    end

    task automatic compare_model();
        n_vec++;
        if (dut_state !== m_state || dut_level !== LEVEL_W'(m_level) ||
            dut_lives !== LIVES_W'(m_lives) || dut_respawn !== m_respawn ||
            dut_sv !== m_sv || dut_sound !== m_sound) begin
            n_err++;
            $display("FAIL model_cmp t=%0t: got st=%0d lvl=%0d lives=%0d rsp=%0d sv=%0d snd=%0d, expected st=%0d lvl=%0d lives=%0d rsp=%0d sv=%0d snd=%0d",
                     $time, dut_state, dut_level, dut_lives, dut_respawn, dut_sv, dut_sound,
                     m_state, m_level, m_lives, m_respawn, m_sv, m_sound);
        end
    endtask

    task automatic lit(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock of stimulus; outputs are checked 1 ns after the sampling edge.
    task automatic apply(input bit rn, input bit s, input bit p, input bit c,
                         input bit r, input bit t);
        reset_n = rn; start = s; pause = p; collision = c; reached_end = r; tick = t;
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(1, 0, 0, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            apply(1, 0, 0, 0, 0, 0);
            apply(1, 0, 0, 0, 0, 1);
        end
    endtask

    initial begin
        // reset state
        apply(0, 0, 0, 0, 0, 0);
        apply(0, 1, 0, 0, 0, 1);
        lit("rst_state", dut_state, 0);
        lit("rst_level", dut_level, 0);
        lit("rst_lives", dut_lives, 3);
        lit("rst_sound", dut_sound, 0);
        lit("rst_pulses", {dut_respawn, dut_sv}, 0);

        // start from menu
        apply(1, 1, 0, 0, 0, 0);
        lit("start_state", dut_state, 1);
        lit("start_respawn", dut_respawn, 1);
        lit("start_sound", {dut_sv, dut_sound}, {1'b1, 3'd1});
        idle(1);
        lit("start_pulse_len", {dut_respawn, dut_sv}, 0);
        lit("sound_hold", dut_sound, 1);

        // three deaths; entry tick is not counted
        for (int d = 0; d < 3; d++) begin
            apply(1, 0, 0, 1, 0, 1);
            lit("die_state", dut_state, 3);
            lit("die_lives", dut_lives, 2 - d);
            lit("die_sound", {dut_sv, dut_sound}, {1'b1, 3'd2});
            ticks(DT - 1);
            lit("die_59", dut_state, 3);
            apply(1, 0, 0, 1, 0, 1);
            if (d < 2) begin
                lit("die_exit", dut_state, 1);
                lit("die_respawn", dut_respawn, 1);
            end else begin
                lit("gameover_state", dut_state, 5);
                lit("gameover_sound", {dut_sv, dut_sound, dut_respawn}, {1'b1, 3'd4, 1'b0});
            end
        end
        idle(2);
        apply(1, 1, 0, 0, 0, 0);
        lit("go_menu", {dut_state, dut_lives, dut_level}, {3'd0, 2'd3, 4'd0});
        lit("go_menu_nosound", dut_sv, 0);

        // climb through every level to WIN
        apply(1, 1, 0, 0, 0, 0);
        for (int l = 1; l < NL; l++) begin
            apply(1, 0, 0, 0, 1, 0);
            lit("lvlup_level", dut_level, l);
            lit("lvlup_state", {dut_state, dut_sound}, {3'd4, 3'd3});
            ticks(LT - 1);
            lit("lvlup_29", dut_state, 4);
            ticks(1);
            lit("lvlup_exit", {dut_state, dut_respawn}, {3'd1, 1'b1});
        end
        apply(1, 0, 0, 0, 1, 0);
        lit("win_state", dut_state, 6);
        lit("win_sound_level", {dut_sound, dut_level}, {3'd5, 4'd15});
        apply(1, 1, 0, 0, 0, 0);
        lit("win_menu", {dut_state, dut_level}, {3'd0, 4'd0});

        // collision beats reached_end; pause ignores collision
        apply(1, 1, 0, 0, 0, 0);
        apply(1, 0, 0, 1, 1, 0);
        lit("prio_state", {dut_state, dut_level}, {3'd3, 4'd0});
        ticks(DT);
        apply(1, 0, 1, 0, 0, 0);
        lit("pause_on", dut_state, 2);
        apply(1, 1, 0, 1, 1, 1);
        lit("pause_ignore", {dut_state, dut_lives}, {3'd2, 2'd2});
        apply(1, 0, 1, 0, 0, 0);
        lit("pause_off", dut_state, 1);

        // asynchronous reset mid-animation
        apply(1, 0, 0, 1, 0, 0);
        ticks(20);
        #2;
        reset_n = 1'b0;
        #1;
        lit("async_rst", {dut_state, dut_lives}, {3'd0, 2'd3});
        apply(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            apply(1, 0, 0, 0, 0, 1);
            lit("post_rst_quiet", {dut_state, dut_respawn, dut_sv}, {3'd0, 2'b00});
        end

        // randomized play against the model
        for (int i = 0; i < 6000; i++) begin
            apply(($urandom_range(0, 799) != 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 14) == 0),
                  ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 1) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
